regfile: RTL and testbench

REGFILE -- requirements
Module: regfile

---
 rtl/regfile.sv | 110 +++++++++++
 tb/tb_regfile.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile.sv
// ----------------------------------------------------------------------------
// regfile
//   General-purpose register file with two registered read ports and one
//   write port fed by the writeback stage. Entry 0 is hard-wired to zero.
//   Reads have one cycle of latency and bypass a same-cycle write. While the
//   core is stalled the read side holds its captured indices and data, but
//   still picks up writeback results aimed at the held indices.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   asynchronous active-high reset
//   i_stall    in   core stall, freezes the read side
//   i_rs       in   read port A index
//   i_rt       in   read port B index
//   o_rs_data  out  registered read data, port A
//   o_rt_data  out  registered read data, port B
//   i_rd       in   write index (0 = no write)
//   i_rd_data  in   write data
// ----------------------------------------------------------------------------
module regfile #(
    parameter int unsigned CPU_REGNO_WIDTH = 5,
    parameter int unsigned CPU_REG_WIDTH   = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_stall,
    input  logic [CPU_REGNO_WIDTH-1:0] i_rs,
    input  logic [CPU_REGNO_WIDTH-1:0] i_rt,
    output logic [CPU_REG_WIDTH-1:0]   o_rs_data,
    output logic [CPU_REG_WIDTH-1:0]   o_rt_data,
    input  logic [CPU_REGNO_WIDTH-1:0] i_rd,
    input  logic [CPU_REG_WIDTH-1:0]   i_rd_data
);

    localparam int unsigned NUM_REGS = 1 << CPU_REGNO_WIDTH;

    logic [CPU_REG_WIDTH-1:0]   mem_q [NUM_REGS];
    logic [CPU_REGNO_WIDTH-1:0] rs_q, rs_d;
    logic [CPU_REGNO_WIDTH-1:0] rt_q, rt_d;
    logic [CPU_REG_WIDTH-1:0]   rs_data_q, rs_data_d;
    logic [CPU_REG_WIDTH-1:0]   rt_data_q, rt_data_d;

    logic wr_en;
    assign wr_en = (i_rd != '0);

    // Storage: entry 0 is never written, so it stays at its reset value of 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else if (wr_en) begin
            mem_q[i_rd] <= i_rd_data;
        end
    end

    // Read side next state. Unstalled: capture new indices and read with
    // write bypass. Stalled: hold, except refresh a held index that is being
    // written this cycle so the output never goes stale during a stall.
    always_comb begin
        rs_d      = rs_q;
        rt_d      = rt_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;

        if (!i_stall) begin
            rs_d = i_rs;
            rt_d = i_rt;

            if (i_rs == '0) begin
                rs_data_d = '0;
            end else if (i_rs == i_rd) begin
                rs_data_d = i_rd_data;
            end else begin
                rs_data_d = mem_q[i_rs];
            end

            if (i_rt == '0) begin
                rt_data_d = '0;
            end else if (i_rt == i_rd) begin
                rt_data_d = i_rd_data;
            end else begin
                rt_data_d = mem_q[i_rt];
            end
        end else begin
            if (wr_en && (rs_q == i_rd)) begin
                rs_data_d = i_rd_data;
            end
            if (wr_en && (rt_q == i_rd)) begin
                rt_data_d = i_rd_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q      <= '0;
            rt_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
        end else begin
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
        end
    end

    assign o_rs_data = rs_data_q;
    assign o_rt_data = rt_data_q;

endmodule

// File: tb/tb_regfile.sv
module tb_regfile;

    logic        clk;
    logic        rst;
    logic        i_stall;
    logic [4:0]  i_rs;
    logic [4:0]  i_rt;
    logic [4:0]  i_rd;
    logic [31:0] i_rd_data;
    logic [31:0] o_rs_data;
    logic [31:0] o_rt_data;

    int passed = 0;
    int total  = 0;

    regfile #(
        .CPU_REGNO_WIDTH(5),
        .CPU_REG_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_stall(i_stall),
        .i_rs(i_rs),
        .i_rt(i_rt),
        .o_rs_data(o_rs_data),
        .o_rt_data(o_rt_data),
        .i_rd(i_rd),
        .i_rd_data(i_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] d;
        logic [31:0] ers;
        logic [31:0] ert;
    } vec_t;

    vec_t tbl [14];

    // Reference model: architectural register contents plus what each read
    // port is currently presenting and which register it is tracking.
    logic [31:0] regs_m [32];
    logic [31:0] out_a_m, out_b_m;
    logic [4:0]  idx_a_m, idx_b_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic apply(input logic st, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] d);
        i_stall   = st;
        i_rs      = rs;
        i_rt      = rt;
        i_rd      = rd;
        i_rd_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        out_a_m = '0;
        out_b_m = '0;
        idx_a_m = '0;
        idx_b_m = '0;
    endtask

    // Write lands first, then the read observes the updated register file.
    // A stalled port keeps following the register it was looking at.
    task automatic model_step(input logic st, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] d);
        if (rd != 0) regs_m[rd] = d;
        if (!st) begin
            idx_a_m = rs;
            idx_b_m = rt;
            out_a_m = regs_m[rs];
            out_b_m = regs_m[rt];
        end else begin
            if (rd != 0 && rd == idx_a_m) out_a_m = d;
            if (rd != 0 && rd == idx_b_m) out_b_m = d;
        end
    endtask

    function automatic logic [4:0] pick_idx();
        if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 3));
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        //             stall rs  rt  rd  data           exp rs         exp rt
        tbl[0]  = '{1'b0, 5,  31, 0,  32'h0,         32'h0,         32'h0};
        tbl[1]  = '{1'b0, 0,  0,  3,  32'hDEADBEEF,  32'h0,         32'h0};
        tbl[2]  = '{1'b0, 3,  3,  0,  32'h0,         32'hDEADBEEF,  32'hDEADBEEF};
        tbl[3]  = '{1'b0, 0,  3,  0,  32'hFFFFFFFF,  32'h0,         32'hDEADBEEF};
        tbl[4]  = '{1'b0, 0,  0,  0,  32'h0,         32'h0,         32'h0};
        tbl[5]  = '{1'b0, 7,  7,  7,  32'h12345678,  32'h12345678,  32'h12345678};
        tbl[6]  = '{1'b0, 7,  3,  0,  32'h0,         32'h12345678,  32'hDEADBEEF};
        tbl[7]  = '{1'b0, 9,  4,  9,  32'h00000001,  32'h00000001,  32'h0};
        tbl[8]  = '{1'b1, 4,  9,  9,  32'hA5A5A5A5,  32'hA5A5A5A5,  32'h0};
        tbl[9]  = '{1'b1, 4,  9,  4,  32'h44444444,  32'hA5A5A5A5,  32'h44444444};
        tbl[10] = '{1'b0, 4,  9,  0,  32'h0,         32'h44444444,  32'hA5A5A5A5};
        tbl[11] = '{1'b1, 0,  0,  0,  32'hFFFFFFFF,  32'h44444444,  32'hA5A5A5A5};
        tbl[12] = '{1'b0, 31, 30, 31, 32'hCAFEF00D,  32'hCAFEF00D,  32'h0};
        tbl[13] = '{1'b0, 31, 31, 0,  32'h0,         32'hCAFEF00D,  32'hCAFEF00D};

        rst       = 1'b1;
        i_stall   = 1'b0;
        i_rs      = '0;
        i_rt      = '0;
        i_rd      = '0;
        i_rd_data = '0;
        #1;
        check("reset_rs", o_rs_data, 32'h0);
        check("reset_rt", o_rt_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            apply(tbl[i].stall, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].d);
            check($sformatf("vec%0d_rs", i), o_rs_data, tbl[i].ers);
            check($sformatf("vec%0d_rt", i), o_rt_data, tbl[i].ert);
        end

        // Asynchronous reset between edges while stalled with nonzero outputs.
        apply(1'b1, 0, 0, 0, 32'h0);
        check("stall_hold_rs", o_rs_data, 32'hCAFEF00D);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_rs", o_rs_data, 32'h0);
        check("async_rst_rt", o_rt_data, 32'h0);
        // A write presented while reset is held is lost.
        i_rd      = 5;
        i_rd_data = 32'h55555555;
        @(posedge clk);
        #1;
        check("rst_hold_rs", o_rs_data, 32'h0);
        rst = 1'b0;
        apply(1'b0, 31, 7, 0, 32'h0);
        check("post_rst_r31", o_rs_data, 32'h0);
        check("post_rst_r7", o_rt_data, 32'h0);
        apply(1'b0, 5, 9, 0, 32'h0);
        check("lost_write_r5", o_rs_data, 32'h0);
        check("post_rst_r9", o_rt_data, 32'h0);
        apply(1'b0, 2, 3, 2, 32'h0BADF00D);
        check("post_rst_bypass", o_rs_data, 32'h0BADF00D);
        check("post_rst_r3", o_rt_data, 32'h0);

        // Randomized traffic against the reference model.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        model_reset();
        for (int n = 0; n < 600; n++) begin
            logic        st;
            logic [4:0]  rs, rt, rd;
            logic [31:0] d;
            st = ($urandom_range(0, 3) == 0);
            rs = pick_idx();
            rt = pick_idx();
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : pick_idx();
            d  = $urandom;
            apply(st, rs, rt, rd, d);
            model_step(st, rs, rt, rd, d);
            check($sformatf("rand%0d_rs", n), o_rs_data, out_a_m);
            check($sformatf("rand%0d_rt", n), o_rt_data, out_b_m);
        end

        // Sweep every register through port A to confirm final contents.
        for (int r = 0; r < 32; r++) begin
            apply(1'b0, 5'(r), 5'(31 - r), 0, 32'h0);
            model_step(1'b0, 5'(r), 5'(31 - r), 0, 32'h0);
            check($sformatf("sweep%0d_rs", r), o_rs_data, out_a_m);
            check($sformatf("sweep%0d_rt", r), o_rt_data, out_b_m);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
